// File: rtl/soc_bus_pkg.sv
// Shared definitions for the riscv_soc native memory bus: arbiter state
// encoding, the read strobe value and the default timeout error word.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  // A transaction with no byte enables set is a read.
  localparam logic [3:0]  WSTRB_READ       = 4'b0000;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Master index width; wide enough for up to 8 requesters.
  localparam int GRANT_W = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker. The request vector is doubled and
// rotated so that the search always starts just after the last owner;
// the lowest set bit of the rotated window is the winner.
module rr_priority_picker
  import soc_bus_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]    req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               any_req
);

  logic [GRANT_W-1:0] start_idx;
  logic [2*NREQ-1:0]  req_dbl;
  logic [NREQ-1:0]    req_rot;

  // First candidate is the master after the last owner, wrapping at NREQ.
  assign start_idx = (ptr >= GRANT_W'(NREQ - 1)) ? '0 : ptr + 1'b1;
  assign req_dbl   = {req, req};
  assign req_rot   = NREQ'(req_dbl >> start_idx);
  assign any_req   = |req;

  // First-one search; the loop runs downward so the lowest set bit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise an unassigned path infers a latch.
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        winner = GRANT_W'(int'(start_idx) + i
                          - ((int'(start_idx) + i >= NREQ) ? NREQ : 0));
      end
    end
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Round-robin arbiter sharing the memory subsystem port between NREQ bus
// masters. One transaction at a time: IDLE grants, BUSY waits for mem_ready
// or the timeout, RESP delivers a one-cycle response pulse. All outputs are
// registered.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int          NREQ     = 3,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_wstrb,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_valid,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic [GRANT_W-1:0]   grant_id
);

  // Counter is sized for TIMEOUT; a disabled timeout still keeps one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bus_state_e         state, state_next;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GRANT_W-1:0] winner;
  logic               any_req;
  logic               timeout_hit;

  logic [31:0]        sel_addr, sel_wdata;
  logic [3:0]         sel_wstrb;

  logic [NREQ-1:0]    rsp_valid_d;
  logic [31:0]        rsp_rdata_d;
  logic               rsp_err_d;
  logic               mem_valid_d;
  logic [31:0]        mem_addr_d, mem_wdata_d;
  logic [3:0]         mem_wstrb_d;
  logic [GRANT_W-1:0] grant_id_d;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req     (req_valid),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Route the winning master's request fields toward the mem_* registers.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = WSTRB_READ;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == GRANT_W'(i)) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
        sel_wstrb = req_wstrb[4*i +: 4];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: grant, wait for completion or timeout, one response cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_req) state_next = ST_BUSY;
      ST_BUSY: if (mem_ready || timeout_hit) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, rr pointer and timeout counter.
  always_comb begin
    mem_valid_d = mem_valid;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    grant_id_d  = grant_id;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    rsp_valid_d = '0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_wstrb_d = sel_wstrb;
          grant_id_d  = winner;
          ptr_d       = winner;
          cnt_d       = '0;
        end
      end
      ST_BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A memory completion on the expiry cycle still counts as success.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = mem_rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << grant_id;
        end else if (timeout_hit) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = ERR_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NREQ'(1) << grant_id;
        end
      end
      default: ;
    endcase
  end

  // Output, pointer and counter registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= WSTRB_READ;
      grant_id  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ptr_q     <= GRANT_W'(NREQ - 1);
      cnt_q     <= '0;
    end else begin
      mem_valid <= mem_valid_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      grant_id  <= grant_id_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Scoreboard bench for soc_bus_arbiter: directed transactions push expected
// grants and responses into queues; a monitor pops and compares whenever the
// DUT raises mem_valid or rsp_valid. A memory responder answers after a
// programmable number of BUSY cycles (or never).
module tb_soc_bus_arbiter;
  import soc_bus_pkg::*;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_addr;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ*4-1:0]   req_wstrb;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                mem_valid;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_wstrb;
  logic                mem_ready;
  logic [31:0]         mem_rdata;
  logic [GRANT_W-1:0]  grant_id;

  always #5 clk = ~clk;

  soc_bus_arbiter #(
    .NREQ     (NREQ),
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id)
  );

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  grant_t grant_q[$];
  rsp_t   rsp_q[$];

  int tests = 0;
  int fails = 0;

  int     resp_delay = 0;     // BUSY cycles before mem_ready; -1 = never
  logic   stray_ready = 1'b0; // pulse mem_ready while the bus is idle
  int     busy_cycles = 0;
  int     last_valid_len = 0;
  int     valid_len = 0;
  logic   prev_mv = 1'b0;
  logic   stable_bad = 1'b0;
  grant_t exp_g, cap_g;
  rsp_t   exp_r;

  // Memory contents as seen by the bench.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: answers resp_delay cycles after mem_valid rises.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (mem_valid) begin
        if (resp_delay >= 0 && busy_cycles == resp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end
        busy_cycles++;
      end else begin
        busy_cycles = 0;
        if (stray_ready) begin
          mem_ready = 1'b1;
          mem_rdata = 32'h0BAD_0BAD;
        end
      end
    end
  end

  // Monitor: compares grants on mem_valid rise and responses on rsp_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_r = rsp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1) << exp_r.id);
          check("rsp_rdata", rsp_rdata, exp_r.rdata);
          check("rsp_err", 32'(rsp_err), 32'(exp_r.err));
        end
      end
      if (mem_valid && !prev_mv) begin
        valid_len  = 1;
        stable_bad = 1'b0;
        cap_g.addr  = mem_addr;
        cap_g.wdata = mem_wdata;
        cap_g.wstrb = mem_wstrb;
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 32'(mem_valid), 32'd0);
        end else begin
          exp_g = grant_q.pop_front();
          check("grant_id", 32'(grant_id), 32'(exp_g.id));
          check("mem_addr", mem_addr, exp_g.addr);
          check("mem_wdata", mem_wdata, exp_g.wdata);
          check("mem_wstrb", 32'(mem_wstrb), 32'(exp_g.wstrb));
        end
      end else if (mem_valid) begin
        valid_len++;
        if (mem_addr !== cap_g.addr || mem_wdata !== cap_g.wdata || mem_wstrb !== cap_g.wstrb)
          stable_bad = 1'b1;
      end else if (prev_mv) begin
        check("mem_stable", 32'(stable_bad), 32'd0);
        last_valid_len = valid_len;
      end
      prev_mv = mem_valid;
    end
  end

  function automatic void expect_txn(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] wstrb, input logic [31:0] rdata, input logic err);
    grant_t g;
    rsp_t   r;
    g.id = id; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb;
    r.id = id; r.rdata = rdata; r.err = err;
    grant_q.push_back(g);
    rsp_q.push_back(r);
  endfunction

  task automatic set_req(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    req_addr[32*id +: 32] = addr;
    req_wdata[32*id +: 32] = wdata;
    req_wstrb[4*id +: 4]   = wstrb;
    req_valid[id]          = 1'b1;
  endtask

  // Waits for n responses. hold=1: masters keep requesting until the last one.
  task automatic wait_rsps(input int n, input bit hold, output int cycles);
    int got = 0;
    cycles = 0;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid != '0) begin
        got++;
        if (!hold) req_valid = req_valid & ~rsp_valid;
      end
    end
    if (hold) req_valid = '0;
    if (got < n) check("wait_rsp_budget", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int late_rsp;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (3) @(negedge clk);

    // Reset state: every output cleared.
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;

    // 1: single read, ready one cycle after mem_valid. rsp_valid lands in the
    // 4th cycle counting the req_valid cycle as the first.
    @(negedge clk);
    resp_delay = 1;
    expect_txn(0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    set_req(0, 32'h0000_0010, 32'h0, 4'h0);
    wait_rsps(1, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd3);

    // 2: three masters request continuously from reset: 0,1,2,0,1,2.
    @(negedge clk);
    reset = 1'b1;
    resp_delay = 0;
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < NREQ; m++)
        expect_txn(m, 32'h100 + 32'(4 * m), 32'h0, 4'h0, mem_model(32'h100 + 32'(4 * m)), 1'b0);
    for (int m = 0; m < NREQ; m++) set_req(m, 32'h100 + 32'(4 * m), 32'h0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_rsps(6, 1'b1, lat);

    // 3: m1 write to GPIO, held across 5 wait cycles.
    @(negedge clk);
    resp_delay = 5;
    expect_txn(1, 32'h0000_2000, 32'hA5A5_0001, 4'hF, 32'hA5A5_2000, 1'b0);
    set_req(1, 32'h0000_2000, 32'hA5A5_0001, 4'hF);
    wait_rsps(1, 1'b0, lat);
    @(negedge clk);
    check("t3_valid_len", 32'(last_valid_len), 32'd6);

    // 4: timeout after exactly TIMEOUT cycles, then a normal access.
    resp_delay = -1;
    expect_txn(2, 32'h0000_3000, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1);
    set_req(2, 32'h0000_3000, 32'h0, 4'h0);
    wait_rsps(1, 1'b0, lat);
    @(negedge clk);
    check("t4_valid_len", 32'(last_valid_len), 32'd8);
    resp_delay = 2;
    expect_txn(0, 32'h0000_0040, 32'h0, 4'h0, mem_model(32'h40), 1'b0);
    set_req(0, 32'h0000_0040, 32'h0, 4'h0);
    wait_rsps(1, 1'b0, lat);

    // 5: mem_ready on the expiry cycle wins.
    @(negedge clk);
    resp_delay = 7;
    expect_txn(1, 32'h0000_0050, 32'h0, 4'h0, mem_model(32'h50), 1'b0);
    set_req(1, 32'h0000_0050, 32'h0, 4'h0);
    wait_rsps(1, 1'b0, lat);
    @(negedge clk);
    check("t5_valid_len", 32'(last_valid_len), 32'd8);

    // mem_ready while idle is ignored.
    stray_ready = 1'b1;
    repeat (3) @(negedge clk);
    stray_ready = 1'b0;
    check("stray_mem_valid", 32'(mem_valid), 32'd0);
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);

    // 6: reset during BUSY abandons the access.
    resp_delay = -1;
    grant_q.push_back('{id: 2, addr: 32'h60, wdata: 32'h0, wstrb: 4'h0});
    set_req(2, 32'h0000_0060, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("t6_busy", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("t6_mem_valid", 32'(mem_valid), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    late_rsp = 0;
    repeat (2) @(negedge clk) if (rsp_valid != '0) late_rsp++;
    reset = 1'b0;
    repeat (4) @(negedge clk) if (rsp_valid != '0) late_rsp++;
    check("t6_no_late_rsp", 32'(late_rsp), 32'd0);
    resp_delay = 0;
    expect_txn(0, 32'h0000_0070, 32'h0, 4'h0, mem_model(32'h70), 1'b0);
    expect_txn(2, 32'h0000_0074, 32'h0, 4'h0, mem_model(32'h74), 1'b0);
    set_req(0, 32'h0000_0070, 32'h0, 4'h0);
    set_req(2, 32'h0000_0074, 32'h0, 4'h0);
    wait_rsps(2, 1'b0, lat);

    repeat (3) @(negedge clk);
    check("sb_rsp_drained", 32'(rsp_q.size()), 32'd0);
    check("sb_grant_drained", 32'(grant_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
